// File: rtl/mux16_arbiter.sv
// Round-robin arbiter for two 16-bit requesters sharing one Mux16 into a single-entry
// valid/ready output register; grants are held for bursts of up to MAX_BURST words.
module mux16_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CW        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic        sel,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          out_valid_d;
  logic [15:0]   out_data_d;

  logic          load;
  logic          grant_any;
  logic          grant_b;
  logic [CW-1:0] grant_cnt;

  // State and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

  // Owner decision, handshake and next-state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    sel         = sel_q;
    grant_any   = 1'b0;
    grant_b     = 1'b0;
    grant_cnt   = ONE_CNT;
    load        = ~out_valid | out_ready;

    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) begin
          grant_any = 1'b1;
          grant_b   = ~last_q;
        end else if (a_valid || b_valid) begin
          grant_any = 1'b1;
          grant_b   = b_valid;
        end
      end
      OWN_A: begin
        if (a_valid && (cnt_q < MAX_CNT)) begin
          grant_any = 1'b1;
          grant_cnt = cnt_q + ONE_CNT;
        end else if (b_valid) begin
          grant_any = 1'b1;
          grant_b   = 1'b1;
        end else if (a_valid) begin
          grant_any = 1'b1;
        end
      end
      OWN_B: begin
        if (b_valid && (cnt_q < MAX_CNT)) begin
          grant_any = 1'b1;
          grant_b   = 1'b1;
          grant_cnt = cnt_q + ONE_CNT;
        end else if (a_valid) begin
          grant_any = 1'b1;
        end else if (b_valid) begin
          grant_any = 1'b1;
          grant_b   = 1'b1;
        end
      end
      default: begin
        grant_any = 1'b0;
      end
    endcase

    // Backpressure (load=0) and reset both leave every register untouched here
    if (load && rst_n) begin
      if (grant_any) begin
        a_ready     = ~grant_b;
        b_ready     = grant_b;
        sel         = grant_b;
        out_data_d  = grant_b ? b_data : a_data;
        out_valid_d = 1'b1;
        state_d     = grant_b ? OWN_B : OWN_A;
        last_d      = grant_b;
        sel_d       = grant_b;
        cnt_d       = grant_cnt;
      end else begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
        cnt_d       = '0;
      end
    end
  end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Bench for mux16_arbiter: two instances (MAX_BURST 4 and 2) fed the same stimulus and
// checked every cycle against a transaction-level round-robin model.
module tb_mux16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, out_ready;
  logic [15:0] a_data, b_data;

  logic [1:0]  ar, br, sl, ov;
  logic [15:0] od [2];

  always #5 clk = ~clk;

  mux16_arbiter #(.MAX_BURST(4), .CW(3)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(ar[0]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(br[0]),
    .sel(sl[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready)
  );

  mux16_arbiter #(.MAX_BURST(2), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(ar[1]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(br[1]),
    .sel(sl[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready)
  );

  int tests = 0;
  int fails = 0;

  // Model: owner 0=none,1=A,2=B; burst length; last owner; register contents
  int          m_owner [2];
  int          m_burst [2];
  int          m_last  [2];
  int          m_max   [2] = '{4, 2};
  logic        m_sel   [2];
  logic        m_ov    [2];
  logic [15:0] m_od    [2];
  int          last_pick [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_burst[k] = 0; m_last[k] = 2;
      m_sel[k] = 1'b0; m_ov[k] = 1'b0; m_od[k] = 16'h0000;
    end
  endtask

  // Who gets the next word, and what the burst length becomes
  function automatic int pick(input int k, output int burst);
    int me, other;
    bit me_v, other_v;
    burst = 1;
    if (m_owner[k] == 0) begin
      if (a_valid && b_valid) return (m_last[k] == 1) ? 2 : 1;
      if (a_valid) return 1;
      if (b_valid) return 2;
      burst = 0;
      return 0;
    end
    me      = m_owner[k];
    other   = 3 - me;
    me_v    = (me == 1) ? a_valid : b_valid;
    other_v = (other == 1) ? a_valid : b_valid;
    if (me_v && m_burst[k] < m_max[k]) begin
      burst = m_burst[k] + 1;
      return me;
    end
    if (other_v) return other;
    if (me_v) return me;
    burst = 0;
    return 0;
  endfunction

  // One clock: check combinational and registered outputs, then advance the model
  task automatic cycle();
    int  ch [2];
    int  bl [2];
    bit  load;
    #2;
    for (int k = 0; k < 2; k++) begin
      load  = !m_ov[k] || out_ready;
      ch[k] = pick(k, bl[k]);
      if (!load) ch[k] = -1;
      chk($sformatf("a_ready[%0d]", k), 16'(ar[k]), 16'(ch[k] == 1));
      chk($sformatf("b_ready[%0d]", k), 16'(br[k]), 16'(ch[k] == 2));
      chk($sformatf("sel[%0d]", k), 16'(sl[k]), (ch[k] > 0) ? 16'(ch[k] == 2) : 16'(m_sel[k]));
      chk($sformatf("out_valid[%0d]", k), 16'(ov[k]), 16'(m_ov[k]));
      chk($sformatf("out_data[%0d]", k), od[k], m_od[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      last_pick[k] = ch[k];
      if (ch[k] > 0) begin
        m_ov[k]    = 1'b1;
        m_od[k]    = (ch[k] == 2) ? b_data : a_data;
        m_owner[k] = ch[k];
        m_last[k]  = ch[k];
        m_sel[k]   = (ch[k] == 2);
        m_burst[k] = bl[k];
      end else if (ch[k] == 0) begin
        m_ov[k]    = 1'b0;
        m_owner[k] = 0;
        m_burst[k] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_ov"}, 16'(ov[k]), 16'h0);
      chk({tag, "_od"}, od[k], 16'h0000);
      chk({tag, "_sel"}, 16'(sl[k]), 16'h0);
      chk({tag, "_rdy"}, 16'({ar[k], br[k]}), 16'h0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] seq [6];
  int ia, ib;

  initial begin
    // Reset with both requesters asserting
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 16'h1234; b_data = 16'h5678;
    model_reset();
    #3;
    check_reset_outputs("rst_init");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_edge");
    @(negedge clk);
    rst_n = 1'b1;

    // A only, three back-to-back words
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_data = 16'(i + 1);
      cycle();
      chk("a_only_word", od[0], 16'(i + 1));
    end
    a_valid = 1'b0;
    cycle();
    cycle();

    // Both always valid from reset: MAX_BURST=2 instance must give A0,A1,B0,B1,A2,A3
    do_reset();
    seq = '{16'hAAA0, 16'hAAA1, 16'hBBB0, 16'hBBB1, 16'hAAA2, 16'hAAA3};
    ia = 0; ib = 0;
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_data = 16'hAAA0 + 16'(ia);
      b_data = 16'hBBB0 + 16'(ib);
      cycle();
      chk("rr_order", od[1], seq[i]);
      if (last_pick[1] == 1) ia++;
      if (last_pick[1] == 2) ib++;
    end

    // Backpressure for three cycles, then release
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_data = 16'hC000 + 16'(i);
      b_data = 16'hD000 + 16'(i);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    cycle();

    // Burst limit with an idle rival, rival joins at word 5
    do_reset();
    a_valid = 1'b1; b_valid = 1'b0; b_data = 16'hB0B0;
    for (int i = 0; i < 9; i++) begin
      a_data = 16'h0A00 + 16'(i);
      if (i == 4) b_valid = 1'b1;
      cycle();
    end

    // Reset mid-burst while B owns and the register is full
    a_valid = 1'b0; b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_data = 16'h0B10 + 16'(i);
      cycle();
    end
    chk("midburst_full", 16'(ov[0]), 16'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b1; b_valid = 1'b1; a_data = 16'hA5A5; b_data = 16'h5A5A;
    rst_n = 1'b1;
    cycle();
    chk("post_rst_grant_a", od[0], 16'hA5A5);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_data    = 16'($urandom);
      b_data    = 16'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
